upscale: RTL and testbench
==========================

Name: upscale

Overview:
- Inverse of the MAC-to-image rescaler. Widens signed IMG_WIDTH image samples to signed NUM_WIDTH MAC/ADD numbers.
- Each sample is sign-extended and left-shifted by a per-beat shift.
- Feeds image data into the accumulator domain, e.g. bias preload or residual add.
- Streaming, two-stage pipeline with valid/ready on both sides.

Parameters:
- NUM_WIDTH, 33, width of the down-stream (MAC) number.
- IMG_WIDTH, 16, width of the up-stream (image) sample; NUM_WIDTH > IMG_WIDTH required.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- shift  in  8  left-shift amount; sampled together with up_data on each accepted beat.
- up_data  in  IMG_WIDTH  signed image sample.
- up_valid  in  1  up_data/shift valid.
- up_ready  out  1  block accepts a beat this cycle.
- dn_data  out  NUM_WIDTH  signed widened number.
- dn_valid  out  1  dn_data valid.
- dn_ready  in  1  downstream accepts dn_data.
- cfg_error  out  1  sticky; set when an accepted shift exceeded SHIFT_MAX.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- SHIFT_MAX = NUM_WIDTH - IMG_WIDTH.
- Reset values: dn_valid=0, dn_data=0, cfg_error=0, both stage valids cleared. up_ready is combinational and reads 1 after reset.
- Beat accepted when up_valid & up_ready. Beat delivered when dn_valid & dn_ready.
- Stage 1, on accept:
  - register sign-extended up_data, NUM_WIDTH bits;
  - register clamped shift = min(shift, SHIFT_MAX);
  - set cfg_error if shift > SHIFT_MAX.
- Stage 2:
  - register (stage1 value <<< clamped shift), truncated to NUM_WIDTH;
  - no overflow is possible because the shift is clamped;
  - low shift bits are zero (see Optional Feature).
- Latency: accepted beat appears on dn_data 2 cycles later if never stalled. Full throughput of 1 beat/cycle.
- Advance rules:
  - stage 2 loads when ~v2 | dn_ready;
  - stage 1 loads when ~v1 | stage 2 loads;
  - up_ready = ~v1 | ~v2 | dn_ready.
  - The combinational ready path is permitted.
- Stall: while dn_valid & ~dn_ready, dn_data holds stable and up_ready drops once both stages are full. No beat is dropped or duplicated.
- Simultaneous accept and deliver on a full pipe: both stages shift, occupancy unchanged.
- Order is preserved; beats are never reordered.
- shift is per-beat. Changing shift between beats affects only subsequently accepted beats.
- cfg_error clears only on rst.
- rst mid-stream: all in-flight beats are discarded and dn_valid=0 on the next cycle.
- Sign rule: dn_data[NUM_WIDTH-1] == up_data[IMG_WIDTH-1] for every beat.

Optional Feature:
- Macro: UPSCALE_MIDPOINT_EN.
- Defined: for clamped shift >= 1, stage 2 ORs 1 << (shift-1) into the result. The value then represents the centre of the quantisation bin; shift=0 output is unchanged.
- Undefined: low shift bits are always zero.
- Latency, handshake and saturation-free behaviour are identical in both builds.

Decomposition:
- Shared package cnn_pkg holds:
  - default NUM_WIDTH and IMG_WIDTH;
  - signed IMG_MAX/IMG_MIN constants, shared with the rescaler;
  - SHIFT_MAX derivation.
- One natural sub-module: pipe_stage, a single valid/ready register slice parameterised by width. Instantiated twice, with the shift/sign-extend logic between instances.

Test Plan:
- IMG=16, NUM=33, dn_ready=1: up_data=0x7FFF, shift=2 -> 2 cycles later dn_data=0x0_0001_FFFC, dn_valid=1, cfg_error=0.
- up_data=0x8000, shift=17 -> dn_data=0x1_0000_0000 (-2^32); up_data=0xFFFF, shift=0 -> 0x1_FFFF_FFFF.
- up_data=0x0001, shift=20 -> clamped to 17, dn_data=0x0_0002_0000, cfg_error=1 and stays 1 until rst.
- Back-to-back stream of 8 values with dn_ready toggled 1,0,0,1,0,1...:
  - exact order and values delivered;
  - dn_data stable during stalls;
  - up_ready=0 only with both stages full.
- Assert rst with 2 beats in flight -> next cycle dn_valid=0, cfg_error=0; the next accepted beat is delivered correctly.
- With UPSCALE_MIDPOINT_EN: up_data=0x0003, shift=4 -> dn_data=0x38. Round trip through the rescaler with shift=4 returns 0x0003.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, image sample limits and shift range for the upscale/rescale pair
package cnn_pkg;
   localparam int DEF_NUM_WIDTH = 33;
   localparam int DEF_IMG_WIDTH = 16;
   localparam logic signed [DEF_IMG_WIDTH-1:0] IMG_MAX = 16'sh7FFF;
   localparam logic signed [DEF_IMG_WIDTH-1:0] IMG_MIN = 16'sh8000;
   function automatic int shift_max(input int num_w, input int img_w);
      return num_w - img_w;
   endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/ready register slice; holds its data while stalled or empty
module pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   assign in_ready = ~out_valid | out_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end
endmodule

// File: rtl/upscale.sv
// upscale: sign-extend and left-shift image samples into the MAC domain; UPSCALE_MIDPOINT_EN adds the bin-centre bit
module upscale
   import cnn_pkg::*;
#(
   parameter int NUM_WIDTH = DEF_NUM_WIDTH,
   parameter int IMG_WIDTH = DEF_IMG_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           shift,
   input  logic [IMG_WIDTH-1:0] up_data,
   input  logic                 up_valid,
   output logic                 up_ready,
   output logic [NUM_WIDTH-1:0] dn_data,
   output logic                 dn_valid,
   input  logic                 dn_ready,
   output logic                 cfg_error
);
   localparam int SHIFT_MAX = shift_max(NUM_WIDTH, IMG_WIDTH);
   localparam logic [7:0] SHIFT_MAX_B = 8'(SHIFT_MAX);
   logic                   over;
   logic                   s1_valid;
   logic                   s2_ready;
   logic [NUM_WIDTH+7:0]   s1_in;
   logic [NUM_WIDTH+7:0]   s1_out;
   logic [NUM_WIDTH-1:0]   s1_num;
   logic [7:0]             s1_sh;
   logic [NUM_WIDTH-1:0]   s2_in;
   assign over  = shift > SHIFT_MAX_B;
   assign s1_in = {{(NUM_WIDTH-IMG_WIDTH){up_data[IMG_WIDTH-1]}}, up_data, over ? SHIFT_MAX_B : shift};
   assign {s1_num, s1_sh} = s1_out;
   // the clamp keeps every shifted sample inside NUM_WIDTH, so the shift cannot overflow
`ifdef UPSCALE_MIDPOINT_EN
   assign s2_in = (s1_num << s1_sh) | (s1_sh != 8'd0 ? NUM_WIDTH'(1) << (s1_sh - 8'd1) : '0);
`else
   assign s2_in = s1_num << s1_sh;
`endif
   pipe_stage #(.W(NUM_WIDTH + 8)) u_s1 (
      .clk(clk), .rst(rst),
      .in_valid(up_valid), .in_ready(up_ready), .in_data(s1_in),
      .out_valid(s1_valid), .out_ready(s2_ready), .out_data(s1_out)
   );
   pipe_stage #(.W(NUM_WIDTH)) u_s2 (
      .clk(clk), .rst(rst),
      .in_valid(s1_valid), .in_ready(s2_ready), .in_data(s2_in),
      .out_valid(dn_valid), .out_ready(dn_ready), .out_data(dn_data)
   );
   always_ff @(posedge clk) begin
      if (rst) cfg_error <= 1'b0;
      else if (up_valid & up_ready & over) cfg_error <= 1'b1;
   end
endmodule

// File: tb/tb_upscale.sv
// tb_upscale: directed and randomized checks of upscale against an arithmetic reference model
module tb_upscale;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  shift = '0;
   logic [15:0] up_data = '0;
   logic        up_valid = 1'b0;
   logic        up_ready;
   logic [32:0] dn_data;
   logic        dn_valid;
   logic        dn_ready = 1'b1;
   logic        cfg_error;
   int          checks = 0;
   int          errors = 0;
   logic        mid_valid;
   logic [32:0] q[$];

   upscale dut (
      .clk(clk), .rst(rst), .shift(shift), .up_data(up_data), .up_valid(up_valid),
      .up_ready(up_ready), .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready),
      .cfg_error(cfg_error)
   );

   always #5 clk = ~clk;

   // value = sample * 2^min(shift,17), plus half a bin when the midpoint build is selected
   function automatic logic [32:0] ref_val(input logic [15:0] d, input logic [7:0] s);
      longint v;
      int k;
      k = (s > 8'd17) ? 17 : int'(s);
      v = longint'($signed(d)) * (longint'(1) << k);
`ifdef UPSCALE_MIDPOINT_EN
      if (k > 0) v = v + (longint'(1) << (k - 1));
`endif
      return v[32:0];
   endfunction

   task automatic beat(input logic [15:0] d, input logic [7:0] s);
      @(negedge clk);
      up_valid = 1'b1; up_data = d; shift = s; dn_ready = 1'b1;
      @(posedge clk);
      #1 up_valid = 1'b0;
      @(negedge clk);
      mid_valid = dn_valid;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_valid got %b want 0", dn_valid); end
      checks++; if (dn_data !== 33'd0) begin errors++; $display("FAIL reset_dn_data got %h want 0", dn_data); end
      checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_cfg_error got %b want 0", cfg_error); end
      checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got %b want 1", up_ready); end
      rst = 1'b0;
   endtask

   task automatic test_directed;
      logic [15:0] d[4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0003};
      logic [7:0]  s[4] = '{8'd2, 8'd17, 8'd0, 8'd4};
      for (int i = 0; i < 4; i++) begin
         beat(d[i], s[i]);
         checks++; if (mid_valid !== 1'b0) begin errors++; $display("FAIL latency_early[%0d] got %b want 0", i, mid_valid); end
         checks++; if (dn_valid !== 1'b1) begin errors++; $display("FAIL latency_valid[%0d] got %b want 1", i, dn_valid); end
         checks++; if (dn_data !== ref_val(d[i], s[i])) begin errors++; $display("FAIL value[%0d] got %h want %h", i, dn_data, ref_val(d[i], s[i])); end
         checks++; if (dn_data[32] !== d[i][15]) begin errors++; $display("FAIL sign[%0d] got %b want %b", i, dn_data[32], d[i][15]); end
      end
      checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL cfg_error_inrange got %b want 0", cfg_error); end
   endtask

   task automatic test_clamp;
      beat(16'h0001, 8'd20);
      checks++; if (dn_data !== ref_val(16'h0001, 8'd20)) begin errors++; $display("FAIL clamp_value got %h want %h", dn_data, ref_val(16'h0001, 8'd20)); end
      checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL clamp_cfg_error got %b want 1", cfg_error); end
      beat(16'h0005, 8'd1);
      repeat (3) @(negedge clk);
      checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL cfg_error_sticky got %b want 1", cfg_error); end
   endtask

   task automatic test_reset_midstream;
      @(negedge clk);
      dn_ready = 1'b0; up_valid = 1'b1; up_data = 16'h1234; shift = 8'd3;
      @(negedge clk);
      up_data = 16'h4321; shift = 8'd5;
      @(negedge clk);
      up_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL midrst_dn_valid got %b want 0", dn_valid); end
      checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL midrst_cfg_error got %b want 0", cfg_error); end
      beat(16'hBEEF, 8'd7);
      checks++; if (dn_valid !== 1'b1 || dn_data !== ref_val(16'hBEEF, 8'd7)) begin
         errors++; $display("FAIL midrst_after got v=%b %h want v=1 %h", dn_valid, dn_data, ref_val(16'hBEEF, 8'd7));
      end
   endtask

   task automatic test_stream(input int n, input bit rnd);
      bit          pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      bit          prev_stall = 0;
      logic [32:0] prev_data = '0;
      logic [32:0] exp;
      logic        exp_rdy;
      q.delete();
      while (got < n && cyc < 40 * n + 50) begin
         @(negedge clk);
         dn_ready = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 8];
         up_valid = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         up_data  = 16'($urandom);
         shift    = 8'($urandom_range(0, rnd ? 24 : 17));
         #1;
         if (prev_stall) begin
            checks++;
            if (dn_valid !== 1'b1 || dn_data !== prev_data) begin
               errors++; $display("FAIL stall_hold cyc %0d got v=%b %h want v=1 %h", cyc, dn_valid, dn_data, prev_data);
            end
         end
         exp_rdy = !(q.size() == 2 && !dn_ready);
         checks++; if (up_ready !== exp_rdy) begin errors++; $display("FAIL up_ready cyc %0d got %b want %b (in flight %0d)", cyc, up_ready, exp_rdy, q.size()); end
         if (dn_valid && dn_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL spurious_beat cyc %0d got %h want no beat", cyc, dn_data);
            end else begin
               exp = q.pop_front();
               if (dn_data !== exp) begin errors++; $display("FAIL stream_value beat %0d got %h want %h", got, dn_data, exp); end
            end
            got++;
         end
         if (up_valid && up_ready) begin
            q.push_back(ref_val(up_data, shift));
            sent++;
         end
         prev_stall = dn_valid && !dn_ready;
         prev_data  = dn_data;
         cyc++;
      end
      checks++; if (got != n) begin errors++; $display("FAIL stream_count got %0d want %0d", got, n); end
      @(negedge clk);
      up_valid = 1'b0; dn_ready = 1'b1;
   endtask

   initial begin
      test_reset;
      test_directed;
      test_clamp;
      test_reset_midstream;
      test_stream(8, 1'b0);
      test_stream(300, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
